// File: rtl/flit_nibble_serializer.sv
// Buffers 32-bit router flits in a small FIFO and streams each one MSB-first as
// eight 4-bit nibbles toward an LVDS transmitter, with sof on the leading nibble.
module flit_nibble_serializer #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      put_flit,
    input  logic             EN_put_flit,
    output logic             RDY_put_flit,
    output logic [3:0]       nib_data,
    output logic             nib_valid,
    output logic             nib_sof,
    input  logic             nib_ready,
    input  logic             link_up,
    output logic [CNT_W-1:0] words_sent,
    output logic             busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       shift_q, shift_d;
    logic [2:0]        beat_q, beat_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       mem_q [FIFO_DEPTH];

    logic full, empty, push, pop, word_done;

    // Readiness comes from registered occupancy only, so a pop never reopens a full buffer early.
    assign full         = (count_q == CW'(FIFO_DEPTH));
    assign empty        = (count_q == '0);
    assign RDY_put_flit = ~RST & ~full;
    assign push         = EN_put_flit & ~full;
    assign word_done    = (state_q == SHIFT) & nib_ready & (beat_q == 3'd7);
    // link_up only gates starting a word; a word in flight always finishes.
    assign pop          = ~empty & link_up & ((state_q == IDLE) | word_done);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        beat_d   = beat_q;
        words_d  = words_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    beat_d  = 3'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (nib_ready) begin
                    shift_d = {shift_q[27:0], 4'h0};
                    beat_d  = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        words_d = words_q + CNT_W'(1);
                        // Back-to-back load keeps the nibble stream gap-free.
                        if (pop) begin
                            shift_d = mem_q[rd_ptr_q];
                            beat_d  = 3'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            beat_q   <= '0;
            words_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            beat_q   <= beat_d;
            words_q  <= words_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: pointers and occupancy define which entries are live.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= put_flit;
        end
    end

    assign nib_valid  = (state_q == SHIFT);
    assign nib_sof    = nib_valid & (beat_q == 3'd0);
    assign nib_data   = nib_valid ? shift_q[31:28] : 4'h0;
    assign busy       = nib_valid | ~empty;
    assign words_sent = words_q;

endmodule

// File: tb/tb_flit_nibble_serializer.sv
// Directed bench for flit_nibble_serializer: drivers queue expected {sof,nibble}
// pairs, a negedge monitor pops and compares every accepted nibble.
module tb_flit_nibble_serializer;

    localparam int CNT_W = 2;

    logic             CLK;
    logic             RST;
    logic [31:0]      put_flit;
    logic             EN_put_flit;
    logic             RDY_put_flit;
    logic [3:0]       nib_data;
    logic             nib_valid;
    logic             nib_sof;
    logic             nib_ready;
    logic             link_up;
    logic [CNT_W-1:0] words_sent;
    logic             busy;

    flit_nibble_serializer #(.FIFO_DEPTH(2), .CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .put_flit     (put_flit),
        .EN_put_flit  (EN_put_flit),
        .RDY_put_flit (RDY_put_flit),
        .nib_data     (nib_data),
        .nib_valid    (nib_valid),
        .nib_sof      (nib_sof),
        .nib_ready    (nib_ready),
        .link_up      (link_up),
        .words_sent   (words_sent),
        .busy         (busy)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];
    logic [CNT_W-1:0] ws_log[$];
    logic [CNT_W-1:0] ws_prev;
    logic ws_log_en = 1'b0;
    int cyc = 0;
    int first_v = -1;
    int last_v = -1;
    int nvalid = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge CLK) begin
        cyc++;
        if (!RST) begin
            if (nib_valid) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                nvalid++;
                if (nib_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_nibble", {27'd0, nib_sof, nib_data}, 32'h1f);
                    end else begin
                        check("nibble", {27'd0, nib_sof, nib_data}, {27'd0, exp_q.pop_front()});
                    end
                end
            end else begin
                check("idle_outputs", {27'd0, nib_sof, nib_data}, 32'd0);
            end
            if (ws_log_en && words_sent != ws_prev) begin
                ws_log.push_back(words_sent);
                ws_prev = words_sent;
            end
        end
    end

    // drivers: all called and returning at #1 after a rising edge
    task automatic push_word(input logic [31:0] w);
        int n = 0;
        while (!RDY_put_flit && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        check("push_rdy_timeout", {31'd0, RDY_put_flit}, 32'd1);
        put_flit    = w;
        EN_put_flit = 1'b1;
        for (int b = 0; b < 8; b++) begin
            exp_q.push_back({(b == 0), w[31-4*b -: 4]});
        end
        @(posedge CLK); #1;
        EN_put_flit = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(posedge CLK); #1;
            n++;
        end
        check(name, {31'd0, (n < 300)}, 32'd1);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        EN_put_flit = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_valid", {31'd0, nib_valid}, 32'd0);
        check("rst_rdy", {31'd0, RDY_put_flit}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_words", {30'd0, words_sent}, 32'd0);
        RST = 1'b0;
        #1;
        check("rdy_after_rst", {31'd0, RDY_put_flit}, 32'd1);
        @(posedge CLK); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        put_flit = '0;
        EN_put_flit = 1'b0;
        nib_ready = 1'b1;
        link_up = 1'b1;
        do_reset();

        // single word, latency and MSB-first order
        push_word(32'h12345678);
        check("lat_not_yet", {31'd0, nib_valid}, 32'd0);
        @(posedge CLK); #1;
        check("lat_valid", {31'd0, nib_valid}, 32'd1);
        check("lat_sof", {31'd0, nib_sof}, 32'd1);
        check("lat_data", {28'd0, nib_data}, 32'h1);
        wait_idle("single_drain");
        check("single_words", {30'd0, words_sent}, 32'd1);

        // backpressure at beat 2
        push_word(32'hA5A5F00F);
        repeat (3) @(posedge CLK);
        #1;
        nib_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_data", {28'd0, nib_data}, 32'hA);
            check("bp_hold_sof", {31'd0, nib_sof}, 32'd0);
            @(posedge CLK); #1;
        end
        nib_ready = 1'b1;
        wait_idle("bp_drain");
        check("bp_words", {30'd0, words_sent}, 32'd2);

        // full buffer, ignored enqueue, back-to-back stream
        first_v = -1; last_v = -1; nvalid = 0;
        push_word(32'h11111111);
        push_word(32'h22222222);
        push_word(32'h33333333);
        check("full_rdy", {31'd0, RDY_put_flit}, 32'd0);
        put_flit = 32'hBAD0BAD0;
        EN_put_flit = 1'b1;
        @(posedge CLK); #1;
        EN_put_flit = 1'b0;
        wait_idle("b2b_drain");
        check("b2b_count", nvalid, 32'd24);
        check("b2b_contig", last_v - first_v + 1, 32'd24);
        check("b2b_words", {30'd0, words_sent}, 32'd1);

        // link_up gating and mid-word drop
        link_up = 1'b0;
        push_word(32'hDEADBEEF);
        repeat (4) @(posedge CLK);
        #1;
        check("gate_valid", {31'd0, nib_valid}, 32'd0);
        check("gate_busy", {31'd0, busy}, 32'd1);
        link_up = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check("gate_beat4", {28'd0, nib_data}, 32'hB);
        link_up = 1'b0;
        wait_idle("gate_drain");
        check("gate_words", {30'd0, words_sent}, 32'd2);
        link_up = 1'b1;

        // asynchronous reset mid-word with a flit still buffered
        push_word(32'hCAFEF00D);
        push_word(32'h0BADCAFE);
        repeat (3) @(posedge CLK);
        #1;
        check("pre_rst_beat3", {28'd0, nib_data}, 32'hE);
        #1;
        RST = 1'b1;
        exp_q.delete();
        #1;
        check("arst_valid", {31'd0, nib_valid}, 32'd0);
        check("arst_sof", {31'd0, nib_sof}, 32'd0);
        check("arst_data", {28'd0, nib_data}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_rdy", {31'd0, RDY_put_flit}, 32'd0);
        check("arst_words", {30'd0, words_sent}, 32'd0);
        repeat (2) @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        check("rel_rdy", {31'd0, RDY_put_flit}, 32'd1);
        check("rel_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check("rel_no_stale", {31'd0, nib_valid}, 32'd0);
        end
        push_word(32'h9ABCDEF0);
        @(posedge CLK); #1;
        check("rel_sof", {27'd0, nib_sof, nib_data}, 32'h19);
        wait_idle("rel_drain");
        check("rel_words", {30'd0, words_sent}, 32'd1);

        // counter wrap with 2-bit counter
        do_reset();
        ws_log.delete();
        ws_prev = '0;
        ws_log_en = 1'b1;
        push_word(32'h0000000F);
        push_word(32'hF0F0F0F0);
        push_word(32'h13579BDF);
        push_word(32'h2468ACE0);
        push_word(32'hFFFFFFFF);
        wait_idle("wrap_drain");
        @(posedge CLK); #1;
        ws_log_en = 1'b0;
        check("wrap_len", ws_log.size(), 32'd5);
        if (ws_log.size() == 5) begin
            check("wrap_0", {30'd0, ws_log[0]}, 32'd1);
            check("wrap_1", {30'd0, ws_log[1]}, 32'd2);
            check("wrap_2", {30'd0, ws_log[2]}, 32'd3);
            check("wrap_3", {30'd0, ws_log[3]}, 32'd0);
            check("wrap_4", {30'd0, ws_log[4]}, 32'd1);
        end

        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flit_nibble_serializer.md
FLIT_NIBBLE_SERIALIZER -- requirements
Module: flit_nibble_serializer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, flit buffer depth (power of two, >= 2).
REQ-002 SHALL have parameter CNT_W, default 16, width of the sent-word counter.
REQ-003 SHALL have port CLK  input  1  single clock for all state.
REQ-004 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port put_flit  input  32  flit word from the router get side.
REQ-006 SHALL have port EN_put_flit  input  1  enqueue strobe, honoured only while RDY_put_flit=1.
REQ-007 SHALL have port RDY_put_flit  output  1  buffer not full.
REQ-008 SHALL have port nib_data  output  4  current nibble toward the LVDS transmitter.
REQ-009 SHALL have port nib_valid  output  1  nib_data valid.
REQ-010 SHALL have port nib_sof  output  1  marks the first (most significant) nibble of a word.
REQ-011 SHALL have port nib_ready  input  1  LVDS transmitter accepts the nibble this cycle.
REQ-012 SHALL have port link_up  input  1  far-end receiver ready (RDY_from_recv); gates word starts only.
REQ-013 SHALL have port words_sent  output  CNT_W  count of fully transmitted words.
REQ-014 SHALL have port busy  output  1  high when in SHIFT or buffer non-empty.

Function
REQ-015 SHALL write put_flit into a FIFO_DEPTH-entry FIFO on a rising CLK edge when EN_put_flit=1 and RDY_put_flit=1; EN while RDY=0 is ignored, no state change.
REQ-016 SHALL drive RDY_put_flit from registered occupancy only: 1 iff count < FIFO_DEPTH; a same-cycle pop does not reopen a full FIFO.
REQ-017 SHALL implement a two-state FSM: IDLE, SHIFT.
REQ-018 In IDLE, when FIFO non-empty and link_up=1, SHALL load head into a 32-bit shift register, pop it, clear beat counter (3 bits), enter SHIFT.
REQ-019 Latency SHALL be: word enqueued at edge N -> nib_valid=1 with nib_sof=1 after edge N+1 (if link_up=1 and FSM idle).
REQ-020 In SHIFT, SHALL drive nib_valid=1, nib_data=shift[31:28], nib_sof=1 iff beat=0.
REQ-021 In SHIFT with nib_ready=1, SHALL shift left by 4 and increment beat; with nib_ready=0 SHALL hold nib_data, nib_sof, beat unchanged.
REQ-022 On acceptance of beat 7, SHALL increment words_sent (mod 2^CNT_W, wraps to 0) and, if FIFO non-empty and link_up=1, load the next word in the same edge (zero-bubble back-to-back), else return to IDLE.
REQ-023 Nibble order SHALL be MSB first: bits[31:28], [27:24], ... [3:0].
REQ-024 link_up falling mid-word SHALL NOT abort the word; it blocks only the next start.
REQ-025 Simultaneous enqueue and pop SHALL keep count unchanged and preserve FIFO order.
REQ-026 In IDLE, nib_valid, nib_sof, nib_data SHALL be 0.
REQ-027 Sustained throughput SHALL be one word per 8 cycles with nib_ready=1, link_up=1.

Reset
REQ-028 While RST=1, SHALL force FSM=IDLE, FIFO empty, shift register=0, beat=0, words_sent=0, nib_valid=0, nib_sof=0, nib_data=0, busy=0, RDY_put_flit=0.
REQ-029 RST asserted mid-word SHALL discard the partial word and all buffered flits immediately (asynchronous); RDY_put_flit=1 on the first cycle after release.

Verification
REQ-030 Single word: enqueue 0x12345678, link_up=1, nib_ready=1 -> nibbles 1,2,...,8 on 8 consecutive cycles, nib_sof only on 1, words_sent=1.
REQ-031 Backpressure: nib_ready=0 for 3 cycles at beat 2 of 0xA5A5F00F -> nib_data holds 0xA for 3 cycles, then continues 5,F,0,0,F with no loss.
REQ-032 Full/back-to-back: enqueue 0x11111111, 0x22222222, 0x33333333 rapidly with FIFO_DEPTH=2 -> RDY_put_flit drops when full; 24 contiguous nib_valid cycles, sof at cycles 0,8,16.
REQ-033 link_up gating: link_up=0 with 0xDEADBEEF queued -> nib_valid stays 0, busy=1; raise link_up -> word sent; drop link_up at beat 4 -> word still completes.
REQ-034 Counter wrap: CNT_W=2, send 5 words -> words_sent sequence 1,2,3,0,1.
REQ-035 Reset mid-word: assert RST at beat 3 -> all outputs 0 asynchronously; after release, FIFO empty, RDY_put_flit=1, new word serializes from sof.
